// File: rtl/lm07_pkg.sv
// Shared constants and FSM state encoding for the LM07 sensor emulator.
package lm07_pkg;

    localparam int          LM07_TEMP_BITS     = 11;
    localparam int          LM07_FRAME_BITS    = 16;
    localparam int          LM07_PAD_BITS      = LM07_FRAME_BITS - LM07_TEMP_BITS;
    localparam logic [15:0] LM07_DEV_ID        = 16'h8001;
    // Weight of one temperature LSB in milli-degC, used by the reader's BCD path.
    localparam int          LM07_TEMP_LSB_MDEG = 250;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } lm07_state_e;

endpackage

// File: rtl/lm07_sync_edge.sv
// Multi-flop synchroniser followed by a rise/fall detector for one async input.
module lm07_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/lm07_sensor_emu.sv
// LM70-style SPI temperature sensor emulator, oversampling cs_n/sck on clk.
// Define LM07_ID_EN to append the 16-bit device ID after the data bits.
//   state    | meaning
//   ST_IDLE  | deselected, sio_oe low, waiting for cs_fall
//   ST_SHIFT | shifting data bits out on each sck_fall
//   ST_DONE  | data bits sent; trailing ID bits or zeros until cs_rise
module lm07_sensor_emu
    import lm07_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TEMP_BITS   = LM07_TEMP_BITS,
    parameter int FRAME_BITS  = LM07_FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 sck,
    input  logic [TEMP_BITS-1:0] temp_in,
    input  logic                 temp_wr,
    output logic                 sio,
    output logic                 sio_oe,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int PAD_BITS = FRAME_BITS - TEMP_BITS;
`ifdef LM07_ID_EN
    localparam int ID_BITS = 16;
`else
    localparam int ID_BITS = 0;
`endif
    localparam int TOTAL_BITS = FRAME_BITS + ID_BITS;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(TOTAL_BITS);

    logic w_cs_rise, w_cs_fall, w_sck_fall, w_unused_sck_rise;
    logic [TOTAL_BITS-1:0] w_frame;

    lm07_state_e           r_state;
    logic [TEMP_BITS-1:0]  r_hold, r_pend;
    logic                  r_pend_vld;
    logic [TOTAL_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sio, r_sio_oe, r_busy, r_frame_done;

    lm07_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    lm07_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(sck),
        .o_rise (w_unused_sck_rise),
        .o_fall (w_sck_fall)
    );

`ifdef LM07_ID_EN
    assign w_frame = {r_hold, {PAD_BITS{1'b1}}, LM07_DEV_ID};
`else
    assign w_frame = {r_hold, {PAD_BITS{1'b1}}};
`endif

    // A write landing on the cs_rise cycle is newer than any pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (temp_wr && (!r_busy || w_cs_rise)) begin
            r_hold     <= temp_in;
            r_pend_vld <= 1'b0;
        end else if (temp_wr) begin
            r_pend     <= temp_in;
            r_pend_vld <= 1'b1;
        end else if (w_cs_rise && r_pend_vld) begin
            r_hold     <= r_pend;
            r_pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_sio        <= 1'b0;
            r_sio_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_cs_rise) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_sio    <= 1'b0;
                r_sio_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_shift  <= w_frame;
                            r_sio    <= w_frame[TOTAL_BITS-1];
                            r_sio_oe <= 1'b1;
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_ONE;
                            r_state  <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_sck_fall) begin
                            r_shift <= r_shift << 1;
                            r_sio   <= r_shift[TOTAL_BITS-2];
                            r_cnt   <= r_cnt + CNT_ONE;
                            if (r_cnt == CNT_LAST_DATA) begin
                                r_frame_done <= 1'b1;
                                r_state      <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Zeros shift in behind the frame, so sio reads 0 once it is exhausted.
                        if (w_sck_fall) begin
                            r_shift <= r_shift << 1;
                            r_sio   <= r_shift[TOTAL_BITS-2];
                            if (r_cnt != CNT_MAX) begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sio        = r_sio;
    assign sio_oe     = r_sio_oe;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lm07_sensor_emu.sv
// Randomised SPI-read bench for lm07_sensor_emu against a frame-level reference model.
module tb_lm07_sensor_emu;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst, cs_n, sck, temp_wr;
    logic [10:0] temp_in;
    logic        sio, sio_oe, busy, frame_done;

    int n_total  = 0;
    int n_bad    = 0;
    int fd_total = 0;

    logic [10:0] m_hold, m_pend;
    logic        m_pend_vld;
    logic [31:0] cap;

    lm07_sensor_emu dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sck       (sck),
        .temp_in   (temp_in),
        .temp_wr   (temp_wr),
        .sio       (sio),
        .sio_oe    (sio_oe),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_total++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: 32 bits the initiator should see -- frame word then ID or zeros.
    function automatic logic [31:0] exp_word(input logic [10:0] t);
        logic [31:0] f;
        f = 32'(t) * 32 + 31;
`ifdef LM07_ID_EN
        return (f << 16) | 32'h0000_8001;
`else
        return f << 16;
`endif
    endfunction

    task automatic write_idle(input logic [10:0] v);
        temp_in = v;
        temp_wr = 1'b1;
        @(negedge clk);
        temp_wr = 1'b0;
        m_hold  = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_read(input int nbits, input int wr_at, input logic [10:0] wr_val,
                            input int rst_at, input string tag, output logic [31:0] cap_o);
        logic [31:0] c;
        logic [31:0] exp;
        int          fd0;
        bit          oe_ok;
        bit          aborted;
        c       = '0;
        oe_ok   = 1'b1;
        aborted = 1'b0;
        exp     = exp_word(m_hold) >> (32 - nbits);
        check({tag, "_idle_oe"}, 32'(sio_oe), 32'd0);
        fd0  = fd_total;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        for (int i = 0; i < nbits && !aborted; i++) begin
            if (sio_oe !== 1'b1) oe_ok = 1'b0;
            c   = {c[30:0], sio};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
            if (i == wr_at) begin
                temp_in    = wr_val;
                temp_wr    = 1'b1;
                @(negedge clk);
                temp_wr    = 1'b0;
                m_pend     = wr_val;
                m_pend_vld = 1'b1;
                repeat (HALF - 1) @(negedge clk);
            end else if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({tag, "_rst_oe"}, 32'(sio_oe), 32'd0);
                cs_n       = 1'b1;
                rst        = 1'b0;
                m_hold     = '0;
                m_pend_vld = 1'b0;
                aborted    = 1'b1;
                repeat (HALF) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        if (!aborted) begin
            check({tag, "_data"}, c, exp);
            check({tag, "_oe_hi"}, 32'(oe_ok), 32'd1);
            check({tag, "_fdone"}, 32'(fd_total - fd0), (nbits >= 16) ? 32'd1 : 32'd0);
            if (m_pend_vld) begin
                m_hold     = m_pend;
                m_pend_vld = 1'b0;
            end
        end
        check({tag, "_oe_lo"}, 32'(sio_oe), 32'd0);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        cap_o = c;
    endtask

    initial begin
        rst        = 1'b1;
        cs_n       = 1'b1;
        sck        = 1'b0;
        temp_wr    = 1'b0;
        temp_in    = '0;
        m_hold     = '0;
        m_pend     = '0;
        m_pend_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sio", 32'(sio), 32'd0);
        check("rst_oe", 32'(sio_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fdone", 32'(frame_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        write_idle(11'h064);
        spi_read(16, -1, '0, -1, "p25c", cap);
        check("p25c_const", cap, 32'h0C9F);

        write_idle(11'h7D8);
        spi_read(16, -1, '0, -1, "m10c", cap);
        check("m10c_const", cap, 32'hFB1F);

        write_idle(11'h064);
        spi_read(8, -1, '0, -1, "part8", cap);
        check("part8_const", cap, 32'h0C);
        spi_read(16, -1, '0, -1, "after_part", cap);
        check("after_part_const", cap, 32'h0C9F);

        spi_read(16, 6, 11'h0C8, -1, "midwr", cap);
        check("midwr_const", cap, 32'h0C9F);
        spi_read(16, -1, '0, -1, "midwr_next", cap);
        check("midwr_next_const", cap, 32'h191F);

        write_idle(11'h064);
        spi_read(16, -1, '0, 5, "rstmid", cap);
        spi_read(16, -1, '0, -1, "after_rst", cap);
        check("after_rst_const", cap, 32'h001F);

        write_idle(11'h064);
        spi_read(32, -1, '0, -1, "read32", cap);
`ifdef LM07_ID_EN
        check("read32_const", cap, 32'h0C9F_8001);
`else
        check("read32_const", cap, 32'h0C9F_0000);
`endif

        for (int k = 0; k < 12; k++) begin
            int          n;
            int          w;
            logic [10:0] t;
            if ($urandom_range(0, 1) == 1) write_idle(11'($urandom));
            case ($urandom_range(0, 4))
                0:       n = 8;
                1:       n = 12;
                2:       n = 16;
                3:       n = 24;
                default: n = 32;
            endcase
            w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 2)) : -1;
            t = 11'($urandom);
            spi_read(n, w, t, -1, "rnd", cap);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
